demux_1_5: RTL
==============

DEMUX_1_5 -- requirements
Module: demux_1_5

Interface
REQ-001 The parameter SHALL be: WIDTH, default 8, data width of input and every output.
REQ-002 The port SHALL be: clk  input  1  rising-edge clock, sole clock domain.
REQ-003 The port SHALL be: rst_n  input  1  reset, synchronous and active-low.
REQ-004 The port SHALL be: in_data  input  WIDTH  payload to route.
REQ-005 The port SHALL be: in_selection  input  3  destination index; legal values are 0-4.
REQ-006 The port SHALL be: in_valid  input  1  in_data/in_selection valid this cycle.
REQ-007 The port SHALL be: in_ready  output  1  block accepts the input this cycle.
REQ-008 The ports SHALL be: out0..out4  output  WIDTH each  per-destination payload.
REQ-009 The port SHALL be: out_valid  output  5  bit k set means outk holds a valid word.
REQ-010 The port SHALL be: out_ready  input  5  bit k set means consumer k takes outk this cycle.
REQ-011 The port SHALL be: drop_cnt  output  8  count of illegal-selection words; present only with DEMUX_DROP_CNT_EN.

Function
REQ-012 Each destination k SHALL have one registered holding slot: outk data plus out_valid[k].
REQ-013 An input transfer SHALL occur on a clk edge where in_valid=1 and in_ready=1.
REQ-014 in_ready SHALL be combinational: 1 when in_selection>4; otherwise (!out_valid[s] || out_ready[s]) with s=in_selection.
REQ-015 On a transfer with s<=4, outs SHALL load in_data and out_valid[s] SHALL be 1 the next cycle; the latency is 1 cycle.
REQ-016 On a transfer with in_selection 5-7, the word SHALL be accepted and discarded; no out_valid bit changes due to it.
REQ-017 An output handshake on slot k SHALL occur when out_valid[k]=1 and out_ready[k]=1; out_valid[k] SHALL clear next cycle unless the same edge reloads slot k.
REQ-018 A simultaneous drain and reload of slot k SHALL leave out_valid[k]=1 with the new word, giving full throughput of 1 word/cycle.
REQ-019 While out_valid[k]=1 and out_ready[k]=0, outk and out_valid[k] SHALL hold stable.
REQ-020 Slots SHALL be independent: a stalled slot SHALL NOT block transfers to other destinations.
REQ-021 Data bits of an empty slot (out_valid[k]=0) SHALL be don't-care for consumers but SHALL retain their last value.
REQ-022 Each slot SHALL have one state bit with two states, EMPTY and FULL: EMPTY->FULL on load; FULL->EMPTY on drain without reload; FULL->FULL on hold or drain+reload.

Reset
REQ-023 While rst_n=0 at a clk edge, out_valid SHALL become 5'b0 and out0..out4 SHALL become 0.
REQ-024 Reset SHALL override any transfer on the same edge; words in flight SHALL be lost.
REQ-025 During reset, in_ready SHALL still follow REQ-014 with all slots EMPTY; no transfer takes effect.

Configuration
REQ-026 With macro DEMUX_DROP_CNT_EN defined, drop_cnt SHALL exist, reset to 0, increment by 1 on each REQ-016 transfer, and saturate at 255.
REQ-027 Without DEMUX_DROP_CNT_EN, the drop_cnt port and counter SHALL be absent; all other behaviour is identical.

Verification
REQ-028 Reset, then in_selection=2, in_data=8'hA5, in_valid=1 for one cycle, out_ready=0 -> next cycle out2=8'hA5, out_valid=5'b00100.
REQ-029 Slot 2 FULL, out_ready[2]=0, in_selection=2, in_valid=1 -> in_ready=0, out2 stays 8'hA5; raise out_ready[2] -> the same edge drains A5 and loads new word, out_valid[2] stays 1.
REQ-030 Slot 2 stalled, in_selection=4, in_data=8'h3C -> in_ready=1, next cycle out4=8'h3C, out_valid=5'b10100.
REQ-031 in_selection=6, in_valid=1 for 300 cycles, with macro defined -> in_ready=1 throughout, out_valid unchanged, drop_cnt saturates at 255.
REQ-032 Slots 0 and 3 FULL, drive rst_n=0 together with in_valid=1, in_selection=1 -> next cycle out_valid=5'b0, all outk=0, drop_cnt=0.
REQ-033 Back-to-back stream to selections 0,1,2,3,4 with all out_ready=1 -> each word appears on its output exactly 1 cycle later, in_ready constantly 1.

Source files
------------

// File: rtl/demux_1_5.sv
// demux_1_5: routes one input word per cycle to one of five registered
// destination slots selected by in_selection. Each slot is a one-deep
// buffer with its own valid/ready handshake, so a stalled consumer only
// blocks traffic aimed at its own slot. Selections 5-7 are accepted and
// discarded.
//
// Optional feature: define DEMUX_DROP_CNT_EN to add the 8-bit saturating
// drop_cnt output, which counts discarded (illegal-selection) words.
module demux_1_5 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_selection,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [WIDTH-1:0] out4,
  output logic [4:0]       out_valid,
  input  logic [4:0]       out_ready
`ifdef DEMUX_DROP_CNT_EN
  ,
  output logic [7:0]       drop_cnt
`endif
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } slot_state_e;

  slot_state_e      state_q [5];
  slot_state_e      state_d [5];
  logic [WIDTH-1:0] data_q  [5];
  logic [WIDTH-1:0] data_d  [5];

  logic       sel_legal;
  logic [2:0] sel_idx;
  logic       xfer;
  logic       drop;

  // Input acceptance: illegal selections are always taken; legal ones need
  // the target slot to be empty or draining on this edge.
  always_comb begin
    sel_legal = (in_selection <= 3'd4);
    sel_idx   = sel_legal ? in_selection : 3'd0;
    in_ready  = 1'b1;
    if (sel_legal) begin
      in_ready = (state_q[sel_idx] == S_EMPTY) || out_ready[sel_idx];
    end
    xfer = in_valid && in_ready;
    drop = xfer && !sel_legal;
  end

  // Per-slot next state: a load wins over a drain, so drain+reload stays FULL.
  always_comb begin
    for (int k = 0; k < 5; k++) begin
      state_d[k] = state_q[k];
      data_d[k]  = data_q[k];
      if (xfer && sel_legal && (in_selection == 3'(k))) begin
        state_d[k] = S_FULL;
        data_d[k]  = in_data;
      end else if ((state_q[k] == S_FULL) && out_ready[k]) begin
        state_d[k] = S_EMPTY;
      end
    end
  end

  // Slot registers; reset clears both state and payload and beats any transfer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 5; k++) begin
        state_q[k] <= S_EMPTY;
        data_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < 5; k++) begin
        state_q[k] <= state_d[k];
        data_q[k]  <= data_d[k];
      end
    end
  end

  // Outputs come straight from the slot registers.
  always_comb begin
    for (int k = 0; k < 5; k++) begin
      out_valid[k] = (state_q[k] == S_FULL);
    end
    out0 = data_q[0];
    out1 = data_q[1];
    out2 = data_q[2];
    out3 = data_q[3];
    out4 = data_q[4];
  end

`ifdef DEMUX_DROP_CNT_EN
  logic [7:0] drop_cnt_q;
  logic [7:0] drop_cnt_d;

  // Saturating count of discarded words.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_cnt_q <= 8'd0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule
